fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-bit synchronous FIFO. It pops one byte whenever the FIFO reports non-empty and transmits it as an asynchronous serial frame on a single line: start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It is the FIFO's only reader and owns the FIFO's `rd_en`. Bit timing is derived from the system clock by an integer divider.

---
 rtl/fifo_uart_tx_if.sv | 9 +
 rtl/fifo_uart_tx.sv | 126 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by its single reader: empty flag, read data and pop strobe.
interface fifo_uart_tx_if;
    logic       buf_empty;
    logic [7:0] buf_out;
    logic       rd_en;

    modport master (input buf_empty, input buf_out, output rd_en);
    modport slave  (output buf_empty, output buf_out, input rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and serialises it as start, 8 data bits
// LSB first, optional parity and 1 or 2 stop bits, timed by an integer clock divider.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PAR, STOP} state_e;

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        cell_end;

    assign cell_end = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo.buf_empty) state_d = POP;
            end
            POP: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                // buf_out is valid here, one cycle after the pop strobe
                cnt_d   = '0;
                bit_d   = '0;
                shift_d = fifo.buf_out;
                par_d   = (PARITY == 2) ? ~^fifo.buf_out : ^fifo.buf_out;
                state_d = START;
            end
            START: begin
                if (cell_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cell_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (cell_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                // bit_q counts stop cells so two stop bits reuse the same cell counter
                if (cell_end) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == LAST_STOP) begin
                        bit_d       = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            PAR:     tx = par_q;
            default: tx = 1'b1;
        endcase
    end

    assign fifo.rd_en = (state_q == POP);
    assign busy       = (state_q != IDLE);
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parameterisations fed from queue FIFOs, checked every
// cycle against a frame-timeline model, plus hand-computed expectations for the model.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int PAR_A [3] = '{0, 1, 2};
    localparam int SB_A  [3] = '{1, 2, 1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_uart_tx_if fif0 ();
    fifo_uart_tx_if fif1 ();
    fifo_uart_tx_if fif2 ();

    logic        tx_w    [3];
    logic        busy_w  [3];
    logic [15:0] cnt_w   [3];
    logic        rd_w    [3];
    logic        empty_drv [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0]  out_drv   [3] = '{8'h00, 8'h00, 8'h00};

    assign rd_w[0] = fif0.rd_en;
    assign rd_w[1] = fif1.rd_en;
    assign rd_w[2] = fif2.rd_en;
    assign fif0.buf_empty = empty_drv[0];
    assign fif1.buf_empty = empty_drv[1];
    assign fif2.buf_empty = empty_drv[2];
    assign fif0.buf_out = out_drv[0];
    assign fif1.buf_out = out_drv[1];
    assign fif2.buf_out = out_drv[2];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .fifo(fif0), .tx(tx_w[0]), .busy(busy_w[0]), .frame_cnt(cnt_w[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .fifo(fif1), .tx(tx_w[1]), .busy(busy_w[1]), .frame_cnt(cnt_w[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .fifo(fif2), .tx(tx_w[2]), .busy(busy_w[2]), .frame_cnt(cnt_w[2]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 50) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bytes waiting in each FIFO; the bench is the FIFO.
    logic [7:0] fq [3][$];

    // Model: a frame is a fixed timeline measured in edges from the pop decision.
    bit          m_act  [3] = '{0, 0, 0};
    int          m_k    [3] = '{0, 0, 0};
    logic [7:0]  m_byte [3] = '{8'h00, 8'h00, 8'h00};
    logic [15:0] m_cnt  [3] = '{16'h0, 16'h0, 16'h0};
    logic        rst_seen = 1'b0;
    logic        empty_seen [3] = '{1'b1, 1'b1, 1'b1};

    function automatic int frame_len(input int i);
        return 2 + (9 + ((PAR_A[i] != 0) ? 1 : 0) + SB_A[i]) * CPB;
    endfunction

    function automatic logic frame_bit(input int i, input int idx, input logic [7:0] b);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && PAR_A[i] != 0) return (PAR_A[i] == 1) ? ^b : ~^b;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        rst_seen <= rst;
        for (int i = 0; i < 3; i++) empty_seen[i] <= empty_drv[i];
    end

    // Model step for the edge just passed, compare, then act as the FIFO.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic exp_tx;
            if (!rst_seen) begin
                m_act[i] = 0;
                m_cnt[i] = 16'h0;
            end else if (m_act[i]) begin
                m_k[i]++;
                if (m_k[i] == frame_len(i)) begin
                    m_act[i] = 0;
                    m_cnt[i] = m_cnt[i] + 16'd1;
                end
            end else if (!empty_seen[i]) begin
                m_act[i]  = 1;
                m_k[i]    = 0;
                m_byte[i] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
            end
            if (!m_act[i] || m_k[i] < 2) exp_tx = 1'b1;
            else exp_tx = frame_bit(i, (m_k[i] - 2) / CPB, m_byte[i]);
            check($sformatf("inst%0d tx", i), 32'(tx_w[i]), 32'(exp_tx));
            check($sformatf("inst%0d busy", i), 32'(busy_w[i]), 32'(m_act[i]));
            check($sformatf("inst%0d rd_en", i), 32'(rd_w[i]), 32'(m_act[i] && m_k[i] == 0));
            check($sformatf("inst%0d frame_cnt", i), 32'(cnt_w[i]), 32'(m_cnt[i]));
            if (rd_w[i] && fq[i].size() > 0) out_drv[i] = fq[i].pop_front();
            empty_drv[i] = (fq[i].size() == 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rd(input int i, input int limit);
        int n = 0;
        while (!rd_w[i] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("inst%0d rd_en within %0d cycles", i, limit), 32'(rd_w[i]), 32'd1);
    endtask

    initial begin
        logic [9:0] smp;
        int busy_n, rd_n, stop_hi;
        int rd_t[$];
        logic tx_hist [200];
        bit all_ok;
        logic [7:0] dec;

        // Single byte 0xA5 without parity; 0x07 with even/2-stop and odd/1-stop parity.
        rst = 1'b0;
        fq[0].push_back(8'hA5);
        fq[1].push_back(8'h07);
        fq[2].push_back(8'h07);
        step(3);
        rst = 1'b1;
        wait_rd(0, 10);
        busy_n = 0; rd_n = 0; stop_hi = 0; smp = '0;
        for (int k = 0; k < 56; k++) begin
            if (k > 0) step(1);
            busy_n += int'(busy_w[0]);
            rd_n   += int'(rd_w[0]);
            if (k >= 2 && (k - 2) % 4 == 0 && (k - 2) / 4 < 10) smp[(k - 2) / 4] = tx_w[0];
            if (k == 39) begin
                check("even parity bit of 0x07", 32'(tx_w[1]), 32'd1);
                check("odd parity bit of 0x07", 32'(tx_w[2]), 32'd0);
            end
            if (k >= 42 && k < 50) stop_hi += int'(tx_w[1]);
            if (k == 49) check("2-stop busy in last stop cycle", 32'(busy_w[1]), 32'd1);
            if (k == 50) check("2-stop busy after frame", 32'(busy_w[1]), 32'd0);
        end
        check("0xA5 bit samples", 32'(smp), 32'b11_0100_1010);
        check("0xA5 busy cycles", 32'(busy_n), 32'd42);
        check("0xA5 rd_en pulses", 32'(rd_n), 32'd1);
        check("0xA5 frame_cnt", 32'(cnt_w[0]), 32'd1);
        check("2-stop high cycles after parity", 32'(stop_hi), 32'd8);

        // Back-to-back: three bytes loaded during reset.
        rst = 1'b0;
        fq[0].push_back(8'h01);
        fq[0].push_back(8'h02);
        fq[0].push_back(8'h03);
        step(3);
        rst = 1'b1;
        for (int c = 0; c < 200; c++) begin
            step(1);
            if (rd_w[0]) rd_t.push_back(c);
            tx_hist[c] = tx_w[0];
        end
        check("back-to-back rd_en pulses", 32'(rd_t.size()), 32'd3);
        if (rd_t.size() == 3) begin
            check("rd_en spacing 1-2", 32'(rd_t[1] - rd_t[0]), 32'd43);
            check("rd_en spacing 2-3", 32'(rd_t[2] - rd_t[1]), 32'd43);
            for (int j = 0; j < 3; j++) begin
                for (int b = 0; b < 8; b++) dec[b] = tx_hist[rd_t[j] + 2 + 4 * (b + 1) + 2];
                check($sformatf("decoded byte %0d", j), 32'(dec), 32'(j + 1));
            end
            check("tx high between frames 1-2", 32'(tx_hist[rd_t[0] + 42]), 32'd1);
            check("tx high between frames 2-3", 32'(tx_hist[rd_t[1] + 42]), 32'd1);
        end
        check("back-to-back frame_cnt", 32'(cnt_w[0]), 32'd3);

        // Empty FIFO for 500 cycles.
        all_ok = 1;
        for (int c = 0; c < 500; c++) begin
            step(1);
            for (int i = 0; i < 3; i++)
                if (rd_w[i] !== 1'b0 || tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0) all_ok = 0;
        end
        check("idle outputs while empty", 32'(all_ok), 32'd1);

        // Reset during the third data bit of 0xFF; 0x3C must follow normally.
        fq[0].push_back(8'hFF);
        fq[0].push_back(8'h3C);
        wait_rd(0, 10);
        step(15);
        rst = 1'b0;
        step(1);
        check("tx at reset edge", 32'(tx_w[0]), 32'd1);
        check("busy at reset edge", 32'(busy_w[0]), 32'd0);
        check("frame_cnt at reset edge", 32'(cnt_w[0]), 32'd0);
        rst = 1'b1;
        wait_rd(0, 10);
        for (int k = 0; k <= 50; k++) begin
            if (k > 0) step(1);
            if (k >= 8 && (k - 8) % 4 == 0 && (k - 8) / 4 < 8) dec[(k - 8) / 4] = tx_w[0];
        end
        check("byte after aborted frame", 32'(dec), 32'h3C);
        check("frame_cnt after aborted frame", 32'(cnt_w[0]), 32'd1);
        check("aborted byte not resent", 32'(fq[0].size()), 32'd0);

        // Counter wrap: preload 0xFFFF while idle, then complete one frame.
        @(posedge clk);
        #2;
        force dut0.frame_cnt_d = 16'hFFFF;
        @(posedge clk);
        #2;
        m_cnt[0] = 16'hFFFF;
        release dut0.frame_cnt_d;
        step(1);
        check("frame_cnt preloaded", 32'(cnt_w[0]), 32'hFFFF);
        fq[0].push_back(8'h5A);
        wait_rd(0, 10);
        step(45);
        check("frame_cnt wrapped", 32'(cnt_w[0]), 32'h0000);
        check("busy after wrap frame", 32'(busy_w[0]), 32'd0);

        // Random traffic on all three instances, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            step(1);
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 99) < 4 && fq[i].size() < 4) fq[i].push_back(8'($urandom));
        end
        begin
            int n = 0;
            while (n < 1000 && (fq[0].size() + fq[1].size() + fq[2].size() != 0 ||
                                busy_w[0] || busy_w[1] || busy_w[2])) begin
                step(1);
                n++;
            end
            check("random traffic drained", 32'(n < 1000), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
